// File: rtl/ips_ddr_mm_nch_model_if.sv
// Bus bundle for the multi-port DDR memory model.
// NCH AXI-style user ports packed per signal; port p occupies slice p.
interface ips_ddr_mm_nch_model_if #(
    parameter int NCH             = 3,
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int CTRL_ADDR_WIDTH = 28
);
    localparam int DW = MEM_DQ_WIDTH * 8;

    logic [NCH*CTRL_ADDR_WIDTH-1:0] axi_awaddr;
    logic [NCH*4-1:0]               axi_awlen;
    logic [NCH*4-1:0]               axi_awuser_id;
    logic [NCH-1:0]                 axi_awvalid;
    logic [NCH-1:0]                 axi_awready;
    logic [NCH*DW-1:0]              axi_wdata;
    logic [NCH*DW/8-1:0]            axi_wstrb;
    logic [NCH-1:0]                 axi_wready;
    logic [NCH*4-1:0]               axi_wusero_id;
    logic [NCH-1:0]                 axi_wusero_last;
    logic [NCH*CTRL_ADDR_WIDTH-1:0] axi_araddr;
    logic [NCH*4-1:0]               axi_arlen;
    logic [NCH*4-1:0]               axi_aruser_id;
    logic [NCH-1:0]                 axi_arvalid;
    logic [NCH-1:0]                 axi_arready;
    logic [NCH*DW-1:0]              axi_rdata;
    logic [NCH*4-1:0]               axi_rid;
    logic [NCH-1:0]                 axi_rlast;
    logic [NCH-1:0]                 axi_rvalid;

    modport slave (
        input  axi_awaddr, axi_awlen, axi_awuser_id, axi_awvalid,
        input  axi_wdata, axi_wstrb,
        input  axi_araddr, axi_arlen, axi_aruser_id, axi_arvalid,
        output axi_awready, axi_wready, axi_wusero_id, axi_wusero_last,
        output axi_arready, axi_rdata, axi_rid, axi_rlast, axi_rvalid
    );

    modport master (
        output axi_awaddr, axi_awlen, axi_awuser_id, axi_awvalid,
        output axi_wdata, axi_wstrb,
        output axi_araddr, axi_arlen, axi_aruser_id, axi_arvalid,
        input  axi_awready, axi_wready, axi_wusero_id, axi_wusero_last,
        input  axi_arready, axi_rdata, axi_rid, axi_rlast, axi_rvalid
    );
endinterface

// File: rtl/ips_ddr_mm_nch_model.sv
// Behavioural NCH-port DDR memory model, round-robin, one burst at a time.
// Define DDR_MM_RDLAT_EN to use RD_LAT as read latency (default 1 cycle).
module ips_ddr_mm_nch_model #(
    parameter int NCH             = 3,
    parameter int MEM_DQ_WIDTH    = 32,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_SPACE_AW    = 13,
    parameter int INIT_CYCLES     = 64,
    parameter int RD_LAT          = 4
) (
    input  logic                  core_clk,
    input  logic                  resetn,
    output logic                  ddr_init_done,
    ips_ddr_mm_nch_model_if.slave ifc
);
    localparam int DW  = MEM_DQ_WIDTH * 8;
    localparam int BW  = DW / 8;
    localparam int CAW = CTRL_ADDR_WIDTH;
    localparam int IW  = MEM_SPACE_AW - 3;
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef DDR_MM_RDLAT_EN
    localparam int LAT = RD_LAT;
`else
    localparam int LAT = 1;
`endif
    localparam int CW = $clog2(INIT_CYCLES + RD_LAT + 2);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(LAT - 2);
    localparam logic [PW-1:0] PORT_LAST = PW'(NCH - 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_AWACK = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_ARACK = 3'd4;
    localparam logic [2:0] S_RWAIT = 3'd5;
    localparam logic [2:0] S_RD    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    id_q, id_d;
    logic [3:0]    beat_q, beat_d;

    // Word array is deliberately not reset so contents survive resetn.
    logic [DW-1:0] mem_q [0:(1<<IW)-1];

    logic          req_any, pick_wr;
    logic [PW-1:0] pick;
    int            p;
    logic [IW-1:0] idx;
    logic [DW-1:0] wd;
    logic [BW-1:0] ws;

    assign ddr_init_done = done_q;
    assign idx = addr_q + IW'(beat_q);
    assign wd  = ifc.axi_wdata[gnt_q*DW +: DW];
    assign ws  = ifc.axi_wstrb[gnt_q*BW +: BW];

    // Scan from farthest to nearest so the first requester at/after ptr wins.
    always_comb begin
        req_any = 1'b0;
        pick_wr = 1'b0;
        pick    = ptr_q;
        p       = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            p = int'(ptr_q) + i;
            if (p >= NCH) p = p - NCH;
            if (ifc.axi_awvalid[p] || ifc.axi_arvalid[p]) begin
                req_any = 1'b1;
                pick    = PW'(p);
                pick_wr = ifc.axi_awvalid[p];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (req_any) begin
                    gnt_d   = pick;
                    ptr_d   = (pick == PORT_LAST) ? '0 : pick + 1'b1;
                    state_d = pick_wr ? S_AWACK : S_ARACK;
                end
            end
            S_AWACK: begin
                addr_d  = IW'(ifc.axi_awaddr[gnt_q*CAW +: CAW] >> 3);
                len_d   = ifc.axi_awlen[gnt_q*4 +: 4];
                id_d    = ifc.axi_awuser_id[gnt_q*4 +: 4];
                beat_d  = '0;
                state_d = S_WR;
            end
            S_ARACK: begin
                addr_d  = IW'(ifc.axi_araddr[gnt_q*CAW +: CAW] >> 3);
                len_d   = ifc.axi_arlen[gnt_q*4 +: 4];
                id_d    = ifc.axi_aruser_id[gnt_q*4 +: 4];
                beat_d  = '0;
                cnt_d   = '0;
                state_d = (LAT > 1) ? S_RWAIT : S_RD;
            end
            S_RWAIT: begin
                if (cnt_q == WAIT_LAST) state_d = S_RD;
                else cnt_d = cnt_q + 1'b1;
            end
            S_WR, S_RD: begin
                if (beat_q == len_q) state_d = S_IDLE;
                else beat_d = beat_q + 1'b1;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (state_q == S_WR) begin
            for (int b = 0; b < BW; b++) begin
                if (ws[b]) mem_q[idx][b*8 +: 8] <= wd[b*8 +: 8];
            end
        end
    end

    always_comb begin
        ifc.axi_awready     = '0;
        ifc.axi_wready      = '0;
        ifc.axi_wusero_id   = '0;
        ifc.axi_wusero_last = '0;
        ifc.axi_arready     = '0;
        ifc.axi_rdata       = '0;
        ifc.axi_rid         = '0;
        ifc.axi_rlast       = '0;
        ifc.axi_rvalid      = '0;
        case (state_q)
            S_AWACK: ifc.axi_awready[gnt_q] = 1'b1;
            S_ARACK: ifc.axi_arready[gnt_q] = 1'b1;
            S_WR: begin
                ifc.axi_wready[gnt_q]         = 1'b1;
                ifc.axi_wusero_id[gnt_q*4 +: 4] = id_q;
                ifc.axi_wusero_last[gnt_q]    = (beat_q == len_q);
            end
            S_RD: begin
                ifc.axi_rvalid[gnt_q]         = 1'b1;
                ifc.axi_rdata[gnt_q*DW +: DW] = mem_q[idx];
                ifc.axi_rid[gnt_q*4 +: 4]     = id_q;
                ifc.axi_rlast[gnt_q]          = (beat_q == len_q);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ips_ddr_mm_nch_model.sv
// Directed bench for ips_ddr_mm_nch_model: vector table plus
// hand sequences for init, arbitration order and reset mid-burst.
module tb_ips_ddr_mm_nch_model;
    localparam int NCH = 3;
    localparam int DQ  = 32;
    localparam int CAW = 28;
    localparam int MSA = 13;
    localparam int INI = 64;
    localparam int RDL = 4;
    localparam int DW  = DQ * 8;
    localparam int BW  = DW / 8;
`ifdef DDR_MM_RDLAT_EN
    localparam int LAT = RDL;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        bit             wr;
        int             p;
        logic [CAW-1:0] a;
        int             len;
        logic [3:0]     id;
        logic [DW-1:0]  d0;
        logic [BW-1:0]  st;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic done;
    int   n_run = 0;
    int   n_fail = 0;
    logic [DW-1:0] rexp [16];
    vec_t tv [9];

    ips_ddr_mm_nch_model_if #(.NCH(NCH), .MEM_DQ_WIDTH(DQ),
        .CTRL_ADDR_WIDTH(CAW)) ifc ();

    ips_ddr_mm_nch_model #(
        .NCH(NCH), .MEM_DQ_WIDTH(DQ), .CTRL_ADDR_WIDTH(CAW),
        .MEM_SPACE_AW(MSA), .INIT_CYCLES(INI), .RD_LAT(RDL)
    ) dut (
        .core_clk(clk),
        .resetn(rstn),
        .ddr_init_done(done),
        .ifc(ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_init();
        int  cyc;
        bit  early;
        cyc = 0;
        early = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ifc.axi_awready != 0 || ifc.axi_arready != 0 ||
                ifc.axi_wready != 0 || ifc.axi_rvalid != 0) early = 1;
        end
        chk("init_cycles", DW'(cyc), DW'(INI));
        chk("ready_before_init", DW'(early), DW'(0));
    endtask

    task automatic set_aw(int p, logic [CAW-1:0] a, int len, logic [3:0] id);
        ifc.axi_awaddr[p*CAW +: CAW] = a;
        ifc.axi_awlen[p*4 +: 4]      = 4'(len);
        ifc.axi_awuser_id[p*4 +: 4]  = id;
    endtask

    task automatic do_write(int p, logic [CAW-1:0] a, int len,
                            logic [3:0] id, logic [DW-1:0] d0,
                            logic [BW-1:0] st);
        int n;
        bit got;
        @(negedge clk);
        set_aw(p, a, len, id);
        ifc.axi_wstrb[p*BW +: BW] = st;
        ifc.axi_wdata[p*DW +: DW] = d0;
        ifc.axi_awvalid[p] = 1'b1;
        got = 0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = ifc.axi_awready[p];
        end
        chk("awready", DW'(got), DW'(1));
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            ifc.axi_awvalid[p] = 1'b0;
            ifc.axi_wdata[p*DW +: DW] = d0 + DW'(k);
            chk("wready", DW'(ifc.axi_wready), DW'(1 << p));
            chk("wusero_id", DW'(ifc.axi_wusero_id[p*4 +: 4]), DW'(id));
            chk("wusero_last", DW'(ifc.axi_wusero_last),
                (k == len) ? DW'(1 << p) : DW'(0));
        end
        @(negedge clk);
        chk("wready_after", DW'(ifc.axi_wready), DW'(0));
    endtask

    task automatic do_read(int p, logic [CAW-1:0] a, int len, logic [3:0] id);
        int n;
        bit got;
        @(negedge clk);
        ifc.axi_araddr[p*CAW +: CAW] = a;
        ifc.axi_arlen[p*4 +: 4]      = 4'(len);
        ifc.axi_aruser_id[p*4 +: 4]  = id;
        ifc.axi_arvalid[p] = 1'b1;
        got = 0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = ifc.axi_arready[p];
        end
        chk("arready", DW'(got), DW'(1));
        got = 0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            ifc.axi_arvalid[p] = 1'b0;
            got = ifc.axi_rvalid[p];
        end
        chk("read_latency", DW'(n), DW'(LAT));
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            chk("rvalid", DW'(ifc.axi_rvalid), DW'(1 << p));
            chk("rdata", ifc.axi_rdata[p*DW +: DW], rexp[k]);
            chk("rid", DW'(ifc.axi_rid[p*4 +: 4]), DW'(id));
            chk("rlast", DW'(ifc.axi_rlast), (k == len) ? DW'(1 << p) : DW'(0));
        end
        @(negedge clk);
        chk("rvalid_after", DW'(ifc.axi_rvalid), DW'(0));
        chk("rdata_idle", DW'(ifc.axi_rdata == '0), DW'(1));
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [BW-1:0] sall;
        int            order [$];
        int            n;
        int            drop;
        int            g;
        bit            first0;
        int            exp_order [4];

        ones = '1;
        sall = '1;
        tv[0] = '{1'b1, 0, 28'h0000040, 3, 4'h5, DW'(1), sall};
        tv[1] = '{1'b0, 2, 28'h0000040, 3, 4'h9, DW'(1), sall};
        tv[2] = '{1'b1, 1, 28'h0000080, 0, 4'h3, ones, sall};
        tv[3] = '{1'b1, 1, 28'h0000080, 0, 4'h3, DW'(0), BW'(1)};
        tv[4] = '{1'b0, 0, 28'h0000080, 0, 4'h7, {ones[DW-1:8], 8'h00}, sall};
        tv[5] = '{1'b1, 2, 28'h0001FF8, 1, 4'hA, DW'(256), sall};
        tv[6] = '{1'b0, 1, 28'h0001FF8, 1, 4'h2, DW'(256), sall};
        tv[7] = '{1'b0, 0, 28'h0000000, 0, 4'h4, DW'(257), sall};
        tv[8] = '{1'b0, 1, 28'h0002040, 1, 4'h1, DW'(1), sall};

        ifc.axi_awaddr = '0; ifc.axi_awlen = '0; ifc.axi_awuser_id = '0;
        ifc.axi_awvalid = '0; ifc.axi_wdata = '0; ifc.axi_wstrb = '0;
        ifc.axi_araddr = '0; ifc.axi_arlen = '0; ifc.axi_aruser_id = '0;
        ifc.axi_arvalid = '0;

        repeat (3) @(negedge clk);
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_awready", DW'(ifc.axi_awready), DW'(0));
        chk("rst_wready", DW'(ifc.axi_wready), DW'(0));
        chk("rst_rvalid", DW'(ifc.axi_rvalid), DW'(0));
        chk("rst_rdata", DW'(ifc.axi_rdata == '0), DW'(1));

        set_aw(0, 28'h40, 3, 4'h5);
        ifc.axi_awvalid[0] = 1'b1;
        rstn = 1'b1;
        wait_init();
        ifc.axi_awvalid[0] = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (tv[i].wr) begin
                do_write(tv[i].p, tv[i].a, tv[i].len, tv[i].id, tv[i].d0, tv[i].st);
            end else begin
                for (int k = 0; k <= tv[i].len; k++) rexp[k] = tv[i].d0 + DW'(k);
                do_read(tv[i].p, tv[i].a, tv[i].len, tv[i].id);
            end
        end

        // Reset in the middle of a 4-beat write over a known pattern.
        do_write(0, 28'h200, 3, 4'h6, DW'(160), sall);
        @(negedge clk);
        set_aw(0, 28'h200, 3, 4'h6);
        ifc.axi_wstrb[0 +: BW] = sall;
        ifc.axi_wdata[0 +: DW] = DW'(176);
        ifc.axi_awvalid[0] = 1'b1;
        n = 0;
        while (!ifc.axi_awready[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_awready", DW'(ifc.axi_awready[0]), DW'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ifc.axi_awvalid[0] = 1'b0;
            ifc.axi_wdata[0 +: DW] = DW'(176 + k);
        end
        #2 rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_wready", DW'(ifc.axi_wready), DW'(0));
        chk("mid_rst_wlast", DW'(ifc.axi_wusero_last), DW'(0));
        chk("mid_rst_done", DW'(done), DW'(0));
        @(negedge clk);
        rstn = 1'b1;
        wait_init();

        // All ports request at once, port 0 keeps requesting.
        @(negedge clk);
        for (int q = 0; q < NCH; q++) begin
            set_aw(q, CAW'(28'h100 + 8 * q), 0, 4'(q + 1));
            ifc.axi_wstrb[q*BW +: BW] = sall;
            ifc.axi_wdata[q*DW +: DW] = DW'(192 + q);
        end
        ifc.axi_awvalid = '1;
        n = 0;
        drop = -1;
        first0 = 1;
        while (order.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (drop >= 0) ifc.axi_awvalid[drop] = 1'b0;
            drop = -1;
            if (ifc.axi_awready != 0) begin
                chk("aw_onehot", DW'($onehot(ifc.axi_awready)), DW'(1));
                g = 0;
                for (int q = 0; q < NCH; q++) if (ifc.axi_awready[q]) g = q;
                order.push_back(g);
                if (g == 0 && first0) first0 = 0;
                else drop = g;
            end
        end
        chk("grant_count", DW'(order.size()), DW'(4));
        exp_order = '{0, 1, 2, 0};
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("grant_order", DW'(order[i]), DW'(exp_order[i]));
        @(negedge clk);
        ifc.axi_awvalid = '0;
        repeat (4) @(negedge clk);

        rexp[0] = DW'(176);
        rexp[1] = DW'(177);
        rexp[2] = DW'(162);
        rexp[3] = DW'(163);
        do_read(0, 28'h200, 3, 4'hC);
        rexp[0] = DW'(193);
        do_read(2, 28'h108, 0, 4'hD);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
